// File: rtl/mem_access_seq.sv
// Request sequencer in front of a 16x8 synchronous-read RAM: turns READ/WRITE/FILL/SUM
// requests into RAM cycles and returns exactly one response per accepted request.
module mem_access_seq #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_dat,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_dat,
    output logic          busy,
    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic [DW-1:0] mem_dat_w,
    input  logic [DW-1:0] mem_dat_r
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR,
        S_FILL,
        S_SUM,
        S_RSP
    } state_t;

    localparam logic [AW:0] CNT_LAST    = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_SUM_END = (AW+1)'(DEPTH);

    state_t        state_q;
    logic [DW-1:0] dat_q;
    logic [AW:0]   cnt_q;
    logic [DW-1:0] acc_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_dat_q;
    logic [AW-1:0] mem_adr_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_dat_w_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dat_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            mem_adr_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_dat_w_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        dat_q <= req_dat;
                        cnt_q <= '0;
                        acc_q <= '0;
                        case (req_op)
                            2'b00: begin
                                state_q   <= S_RD_ADDR;
                                mem_adr_q <= req_adr;
                            end
                            2'b01: begin
                                state_q     <= S_WR;
                                mem_adr_q   <= req_adr;
                                mem_dat_w_q <= req_dat;
                                mem_we_q    <= 1'b1;
                            end
                            2'b10: begin
                                state_q     <= S_FILL;
                                mem_adr_q   <= '0;
                                mem_dat_w_q <= req_dat;
                                mem_we_q    <= 1'b1;
                            end
                            default: begin
                                state_q   <= S_SUM;
                                mem_adr_q <= '0;
                            end
                        endcase
                    end
                end
                S_RD_ADDR: state_q <= S_RD_DATA;
                S_RD_DATA: begin
                    rsp_dat_q   <= mem_dat_r;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_WR: begin
                    mem_we_q    <= 1'b0;
                    rsp_dat_q   <= dat_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_FILL: begin
                    if (cnt_q == CNT_LAST) begin
                        mem_we_q    <= 1'b0;
                        rsp_dat_q   <= dat_q + DW'(DEPTH - 1);
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        mem_adr_q   <= AW'(cnt_q + 1'b1);
                        mem_dat_w_q <= dat_q + DW'(cnt_q + 1'b1);
                    end
                end
                S_SUM: begin
                    // Read data lags the address by one cycle, so cycle 0 adds nothing
                    // and the last cycle adds the word fetched for address DEPTH-1.
                    if (cnt_q == CNT_SUM_END) begin
                        rsp_dat_q   <= acc_q + mem_dat_r;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else begin
                        if (cnt_q != '0) begin
                            acc_q <= acc_q + mem_dat_r;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q < CNT_LAST) begin
                            mem_adr_q <= AW'(cnt_q + 1'b1);
                        end
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign mem_adr   = mem_adr_q;
    assign mem_we    = mem_we_q;
    assign mem_dat_w = mem_dat_w_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq with a behavioural RAM and an operation-level
// reference model; directed scenarios followed by randomized requests.
module tb_mem_access_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_adr;
    logic [7:0] req_dat;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_dat;
    logic       busy;
    logic [3:0] mem_adr;
    logic       mem_we;
    logic [7:0] mem_dat_w;
    logic [7:0] mem_dat_r;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mem_access_seq #(.AW(4), .DW(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .busy      (busy),
        .mem_adr   (mem_adr),
        .mem_we    (mem_we),
        .mem_dat_w (mem_dat_w),
        .mem_dat_r (mem_dat_r)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: address registered, data reflects committed writes.
    logic [7:0] ram [16];
    logic [3:0] ram_adr_q = '0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_adr] <= mem_dat_w;
        ram_adr_q <= mem_adr;
    end
    assign mem_dat_r = ram[ram_adr_q];

    // Write-cycle log: every cycle with mem_we high is recorded in order.
    int unsigned we_total = 0;
    logic [3:0]  wr_adr [1024];
    logic [7:0]  wr_dat [1024];
    always @(posedge clk) begin
        if (mem_we) begin
            wr_adr[we_total[9:0]] <= mem_adr;
            wr_dat[we_total[9:0]] <= mem_dat_w;
            we_total <= we_total + 1;
        end
    end

    logic [7:0] ref_mem [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_op(input logic [1:0] op, input logic [3:0] adr, input logic [7:0] dat,
                            output logic [7:0] exp);
        int unsigned s;
        case (op)
            2'd0: exp = ref_mem[adr];
            2'd1: begin ref_mem[adr] = dat; exp = dat; end
            2'd2: begin
                for (int unsigned i = 0; i < 16; i++) ref_mem[i] = 8'((dat + i) % 256);
                exp = 8'((dat + 15) % 256);
            end
            default: begin
                s = 0;
                for (int unsigned i = 0; i < 16; i++) s += ref_mem[i];
                exp = 8'(s % 256);
            end
        endcase
    endtask

    task automatic run_req(input logic [1:0] op, input logic [3:0] adr, input logic [7:0] dat,
                           input int unsigned hold, input bit pend);
        int unsigned start, n, lat, exp_lat, exp_we;
        logic [7:0] exp, held;
        start = we_total;
        req_op = op; req_adr = adr; req_dat = dat; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            check("busy_during_op", {31'd0, busy}, 32'd1);
            tick();
            lat++;
        end
        case (op)
            2'd0: begin exp_lat = 2;  exp_we = 0;  end
            2'd1: begin exp_lat = 1;  exp_we = 1;  end
            2'd2: begin exp_lat = 16; exp_we = 16; end
            default: begin exp_lat = 17; exp_we = 0; end
        endcase
        model_op(op, adr, dat, exp);
        check("rsp_latency", lat, exp_lat);
        check("rsp_dat", {24'd0, rsp_dat}, {24'd0, exp});
        check("we_cycles", we_total - start, exp_we);
        if (op == 2'd1) begin
            check("wr_adr", {28'd0, wr_adr[start[9:0]]}, {28'd0, adr});
            check("wr_dat", {24'd0, wr_dat[start[9:0]]}, {24'd0, dat});
        end
        if (op == 2'd2) begin
            for (int unsigned i = 0; i < 16; i++) begin
                check("fill_adr", {28'd0, wr_adr[10'(start + i)]}, i);
                check("fill_dat", {24'd0, wr_dat[10'(start + i)]}, (dat + i) % 256);
            end
        end
        held = rsp_dat;
        if (pend) begin
            req_valid = 1'b1; req_op = 2'd1; req_adr = 4'd0; req_dat = 8'hAA;
        end
        for (int unsigned h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_dat", {24'd0, rsp_dat}, {24'd0, held});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_rsp_busy", {31'd0, busy}, 32'd0);
        check("post_rsp_we", {31'd0, mem_we}, 32'd0);
    endtask

    initial begin
        logic [7:0] img [16];
        img = '{8'h90, 8'hB3, 8'h23, 8'hFE, 8'hA7, 8'h4F, 8'h2C, 8'h5D,
                8'h57, 8'h93, 8'h5A, 8'h77, 8'h51, 8'h12, 8'h6E, 8'h98};
        for (int i = 0; i < 16; i++) begin
            ram[i]     = img[i];
            ref_mem[i] = img[i];
        end
    end

    initial begin
        int unsigned start;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_adr = '0; req_dat = '0; rsp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_dat", {24'd0, rsp_dat}, 32'd0);
        check("rst_mem_adr", {28'd0, mem_adr}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_dat_w", {24'd0, mem_dat_w}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        run_req(2'd0, 4'd3, 8'h00, 0, 1'b0);   // READ 3
        run_req(2'd3, 4'd0, 8'h00, 0, 1'b0);   // SUM power-up image
        run_req(2'd1, 4'd5, 8'h3C, 0, 1'b0);   // WRITE 5
        run_req(2'd0, 4'd5, 8'h00, 0, 1'b0);
        run_req(2'd0, 4'd4, 8'h00, 0, 1'b0);
        run_req(2'd0, 4'd9, 8'h00, 5, 1'b1);   // held response, pending request
        run_req(2'd2, 4'd0, 8'hF8, 0, 1'b0);   // FILL wrapping seed
        run_req(2'd3, 4'd0, 8'h00, 2, 1'b0);

        // Restore a non-trivial image, then abort a FILL during its 8th write cycle.
        for (int unsigned i = 8; i < 16; i++) run_req(2'd1, 4'(i), 8'(8'h50 + i * 3), 0, 1'b0);
        start = we_total;
        req_op = 2'd2; req_adr = '0; req_dat = 8'h00; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_we_cycles", we_total - start, 32'd8);
        for (int unsigned i = 0; i < 8; i++) ref_mem[i] = 8'(i);
        repeat (3) tick();
        check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        for (int unsigned i = 6; i < 10; i++) run_req(2'd0, 4'(i), 8'h00, 0, 1'b0);

        for (int unsigned k = 0; k < 30; k++) begin
            run_req(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        for (int unsigned i = 0; i < 16; i++) run_req(2'd0, 4'(i), 8'h00, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
